tower_hp_tracker: RTL

Downstream of every troop sprite unit. Collects each troop's per-frame `attackindex` strike code, debits hit points on the left, right and king towers, and drives the tower-destroyed flags (`towerld`, `towerrd`) back into the troops' targeting logic. Also produces HP bar values, hit-flash strobes and the win flag for the HUD and the game state machine. Runs on the frame clock, so each clock edge is one game frame.

---
 rtl/tower_hp_tracker.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tower_hp_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tower_hp_tracker
// Description : Tower hit-point tracker for the frame-clocked game core.
//               Decodes each troop's 4-bit strike code, debits the left,
//               right and king towers, and drives the destroyed flags, HP
//               bars, hit-flash strobes and the sticky win flag.
//               Each Clk edge is one game frame.
// Ports       : Clk         frame clock
//               reset_n     asynchronous active-low reset
//               idle        synchronous restart (same effect as reset)
//               attack_bus  troop i strike code in [4i+3:4i]
//               towerld/towerrd/kingd  tower destroyed flags
//               win         game won, sticky until restart
//               hp_l/hp_r/hp_king      current HP
//               flash       hit strobes {king, right, left}
// Config      : define TOWER_REGEN_EN to enable slow HP regeneration of
//               towers that have not been hit for REGEN_PERIOD frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tower_hp_tracker #(
    parameter int NUM_TROOPS   = 4,
    parameter int TOWER_HP     = 40,
    parameter int KING_HP      = 60,
    parameter int FLASH_FRAMES = 6,
    parameter int REGEN_PERIOD = 120
) (
    input  logic                    Clk,
    input  logic                    reset_n,
    input  logic                    idle,
    input  logic [4*NUM_TROOPS-1:0] attack_bus,
    output logic                    towerld,
    output logic                    towerrd,
    output logic                    kingd,
    output logic                    win,
    output logic [6:0]              hp_l,
    output logic [6:0]              hp_r,
    output logic [6:0]              hp_king,
    output logic [2:0]              flash
);

    localparam int DW = $clog2(NUM_TROOPS + 1);
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    // Tower index: 0 = left, 1 = right, 2 = king
    typedef enum logic {ALIVE = 1'b0, DEAD = 1'b1} tower_state_t;
    typedef enum logic {PLAY  = 1'b0, WON  = 1'b1} game_state_t;

    if (TOWER_HP > 127 || KING_HP > 127 || TOWER_HP < 1 || KING_HP < 1) begin : g_bad_hp
        $error("tower_hp_tracker: starting HP must be in 1..127");
    end
    if (REGEN_PERIOD < 1 || FLASH_FRAMES < 1) begin : g_bad_timing
        $error("tower_hp_tracker: REGEN_PERIOD and FLASH_FRAMES must be >= 1");
    end

    function automatic logic [6:0] start_hp(input int t);
        return (t == 2) ? 7'(KING_HP) : 7'(TOWER_HP);
    endfunction

    tower_state_t   st_q  [3];
    tower_state_t   st_d  [3];
    logic [6:0]     hp_q  [3];
    logic [6:0]     hp_d  [3];
    logic [FW-1:0]  fc_q  [3];
    logic [FW-1:0]  fc_d  [3];
    logic [DW-1:0]  dmg   [3];
    logic [2:0]     accept;
    logic [2:0]     flash_d;
    game_state_t    game_q;
    game_state_t    game_d;

`ifdef TOWER_REGEN_EN
    localparam int RW = $clog2(REGEN_PERIOD + 1);
    logic [RW-1:0]  rc_q  [3];
    logic [RW-1:0]  rc_d  [3];
    logic [3:0]     sub_q [3];
    logic [3:0]     sub_d [3];
`endif

    // Per-frame damage count for each tower across all troops.
    always_comb begin
        for (int t = 0; t < 3; t++) dmg[t] = '0;
        for (int i = 0; i < NUM_TROOPS; i++) begin
            case (attack_bus[4*i +: 4])
                4'd6:    dmg[0] = dmg[0] + DW'(1);
                4'd7:    dmg[1] = dmg[1] + DW'(1);
                4'd5:    dmg[2] = dmg[2] + DW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        game_d = game_q;
        for (int t = 0; t < 3; t++) begin
            st_d[t] = st_q[t];
            hp_d[t] = hp_q[t];
            fc_d[t] = (fc_q[t] != '0) ? fc_q[t] - FW'(1) : '0;
`ifdef TOWER_REGEN_EN
            rc_d[t]  = rc_q[t];
            sub_d[t] = sub_q[t];
`endif
            // King is only vulnerable once a side tower was already dead
            // at the start of this frame.
            accept[t] = (game_q == PLAY) && (st_q[t] == ALIVE) && (dmg[t] != '0) &&
                        ((t != 2) || (st_q[0] == DEAD) || (st_q[1] == DEAD));
            if (accept[t]) begin
                hp_d[t] = (hp_q[t] > 7'(dmg[t])) ? hp_q[t] - 7'(dmg[t]) : 7'd0;
                fc_d[t] = FW'(FLASH_FRAMES);
                if (hp_d[t] == 7'd0) st_d[t] = DEAD;
            end
`ifdef TOWER_REGEN_EN
            if (game_q == PLAY && st_q[t] == ALIVE) begin
                if (accept[t]) begin
                    rc_d[t]  = '0;
                    sub_d[t] = '0;
                end else if (rc_q[t] != RW'(REGEN_PERIOD)) begin
                    rc_d[t] = rc_q[t] + RW'(1);
                end else begin
                    sub_d[t] = sub_q[t] + 4'd1;
                    if (sub_q[t] == 4'd15 && hp_q[t] < start_hp(t))
                        hp_d[t] = hp_q[t] + 7'd1;
                end
            end
`endif
        end
        if (game_q == PLAY && st_d[2] == DEAD) game_d = WON;

        // Restart wins over any strikes in the same frame.
        if (idle) begin
            game_d = PLAY;
            for (int t = 0; t < 3; t++) begin
                st_d[t] = ALIVE;
                hp_d[t] = start_hp(t);
                fc_d[t] = '0;
`ifdef TOWER_REGEN_EN
                rc_d[t]  = '0;
                sub_d[t] = '0;
`endif
            end
        end

        for (int t = 0; t < 3; t++) flash_d[t] = (fc_d[t] != '0);
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            game_q <= PLAY;
            flash  <= 3'b000;
            for (int t = 0; t < 3; t++) begin
                st_q[t] <= ALIVE;
                hp_q[t] <= start_hp(t);
                fc_q[t] <= '0;
`ifdef TOWER_REGEN_EN
                rc_q[t]  <= '0;
                sub_q[t] <= '0;
`endif
            end
        end else begin
            game_q <= game_d;
            flash  <= flash_d;
            for (int t = 0; t < 3; t++) begin
                st_q[t] <= st_d[t];
                hp_q[t] <= hp_d[t];
                fc_q[t] <= fc_d[t];
`ifdef TOWER_REGEN_EN
                rc_q[t]  <= rc_d[t];
                sub_q[t] <= sub_d[t];
`endif
            end
        end
    end

    assign hp_l    = hp_q[0];
    assign hp_r    = hp_q[1];
    assign hp_king = hp_q[2];
    assign towerld = (st_q[0] == DEAD);
    assign towerrd = (st_q[1] == DEAD);
    assign kingd   = (st_q[2] == DEAD);
    assign win     = (game_q == WON);

endmodule
`default_nettype wire
